// File: rtl/soc_eoc_initiator_pkg.sv
// Shared types and widths for the soc/eoc conversion initiator.
package soc_eoc_initiator_pkg;

    localparam int unsigned RES_W  = 16;
    localparam int unsigned HALF_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_SOC_HI   = 3'd2,
        ST_SOC_LO   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    function automatic logic [HALF_W-1:0] hi_half(input logic [RES_W-1:0] v);
        return v[RES_W-1:HALF_W];
    endfunction

    function automatic logic [HALF_W-1:0] lo_half(input logic [RES_W-1:0] v);
        return v[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/soc_eoc_initiator_tmo_counter.sv
// Saturating timeout counter; hit flags when the count has reached TMO_MAX.
module tmo_counter
    import soc_eoc_initiator_pkg::*;
#(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);

    localparam logic [TMO_W-1:0] MAX_V = TMO_W'(TMO_MAX);

    logic [TMO_W-1:0] r_cnt;

    // Holds at MAX_V once reached so the count can never wrap back below it.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == MAX_V);

endmodule

// File: rtl/soc_eoc_initiator.sv
// soc/eoc handshake initiator: starts a conversion, captures the result,
// holds it for a valid/ack consumer and aborts on a per-phase timeout.
module soc_eoc_initiator
    import soc_eoc_initiator_pkg::*;
#(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              start,
    output logic              busy,
    output logic              soc,
    input  logic              eoc,
    input  logic [RES_W-1:0]  conv_out,
    output logic [HALF_W-1:0] res_x,
    output logic [HALF_W-1:0] res_y,
    output logic              res_valid,
    input  logic              res_ack,
    output logic              timeout_err,
    output logic [7:0]        done_cnt
);

    state_t r_state;
    state_t w_next;

    logic w_tmo_hit;
    logic w_tmo_clear;
    logic w_tmo_en;
    logic w_capture;
    logic w_set_err;
    logic w_clr_err;

    logic              r_soc;
    logic              r_busy;
    logic              r_res_valid;
    logic              r_timeout_err;
    logic [HALF_W-1:0] r_res_x;
    logic [HALF_W-1:0] r_res_y;
    logic [7:0]        r_done_cnt;

    tmo_counter #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_tmo (
        .i_clock  (clock),
        .i_reset  (reset_),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_en),
        .o_hit    (w_tmo_hit)
    );

    // The eoc edge is checked before the timeout so a simultaneous edge wins.
    always_comb begin
        w_next      = r_state;
        w_tmo_clear = 1'b0;
        w_tmo_en    = 1'b0;
        w_capture   = 1'b0;
        w_set_err   = 1'b0;
        w_clr_err   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next    = ST_WAIT_RDY;
                    w_clr_err = 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                w_tmo_clear = 1'b1;
                if (eoc) begin
                    w_next = ST_SOC_HI;
                end
            end
            ST_SOC_HI: begin
                if (!eoc) begin
                    w_next      = ST_SOC_LO;
                    w_tmo_clear = 1'b1;
                end else if (w_tmo_hit) begin
                    w_next = ST_ERR;
                end else begin
                    w_tmo_en = 1'b1;
                end
            end
            ST_SOC_LO: begin
                if (eoc) begin
                    w_next    = ST_HOLD;
                    w_capture = 1'b1;
                end else if (w_tmo_hit) begin
                    w_next = ST_ERR;
                end else begin
                    w_tmo_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ack) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERR: begin
                w_set_err = 1'b1;
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset_) begin
            r_state       <= ST_IDLE;
            r_soc         <= 1'b0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_res_x       <= '0;
            r_res_y       <= '0;
            r_done_cnt    <= '0;
        end else begin
            r_state     <= w_next;
            r_soc       <= (w_next == ST_SOC_HI);
            r_busy      <= (w_next != ST_IDLE);
            r_res_valid <= (w_next == ST_HOLD);
            if (w_clr_err) begin
                r_timeout_err <= 1'b0;
            end else if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
            if (w_capture) begin
                r_res_x    <= hi_half(conv_out);
                r_res_y    <= lo_half(conv_out);
                r_done_cnt <= r_done_cnt + 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign soc         = r_soc;
    assign res_valid   = r_res_valid;
    assign timeout_err = r_timeout_err;
    assign res_x       = r_res_x;
    assign res_y       = r_res_y;
    assign done_cnt    = r_done_cnt;

endmodule
